// File: rtl/alu_pkg.sv
// Shared opcode map, opcode classification and FSM encoding for the ALU arbiter.
package alu_pkg;

   localparam logic [4:0] OP_AND = 5'b00000;
   localparam logic [4:0] OP_EOR = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_RSB = 5'b00011;
   localparam logic [4:0] OP_ADD = 5'b00100;
   localparam logic [4:0] OP_ADC = 5'b00101;
   localparam logic [4:0] OP_SBC = 5'b00110;
   localparam logic [4:0] OP_RSC = 5'b00111;
   localparam logic [4:0] OP_TST = 5'b01000;
   localparam logic [4:0] OP_TEQ = 5'b01001;
   localparam logic [4:0] OP_CMP = 5'b01010;
   localparam logic [4:0] OP_CMN = 5'b01011;
   localparam logic [4:0] OP_ORR = 5'b01100;
   localparam logic [4:0] OP_MOV = 5'b01101;
   localparam logic [4:0] OP_BIC = 5'b01110;
   localparam logic [4:0] OP_MVN = 5'b01111;
   localparam logic [4:0] OP1    = 5'b10000;
   localparam logic [4:0] OP2    = 5'b10001;
   localparam logic [4:0] OP3    = 5'b10010;
   localparam logic [4:0] OP4    = 5'b10011;
   localparam logic [4:0] OP5    = 5'b10100;
   localparam logic [4:0] OP6    = 5'b10101;
   localparam logic [4:0] OP7    = 5'b10110;
   localparam logic [4:0] OP8    = 5'b11001;
   localparam logic [4:0] OP9    = 5'b11010;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // TST/TEQ/CMP/CMN: flag-only ops, result is never written back.
   function automatic logic is_test_op(input logic [4:0] op);
      return (op[4:2] == 3'b010);
   endfunction

   function automatic logic is_illegal_op(input logic [4:0] op);
      return (op == 5'b10111) || (op == 5'b11000) || (op >= 5'b11011);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the ALU arbiter.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req0_s;

   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;

   logic [4:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_cin;
   logic [31:0] alu_r;
   logic        alu_c;
   logic        alu_z;
   logic        alu_v;
   logic        alu_n;

   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_r;
   logic        rsp_wr;
   logic        rsp_err;
   logic [3:0]  nzcv;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_s,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_r, alu_c, alu_z, alu_v, alu_n,
      output req0_ready, req1_ready,
      output alu_op, alu_a, alu_b, alu_cin,
      output rsp_valid, rsp_id, rsp_r, rsp_wr, rsp_err, nzcv
   );

   // Requester / ALU environment side.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_s,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_r, alu_c, alu_z, alu_v, alu_n,
      input  req0_ready, req1_ready,
      input  alu_op, alu_a, alu_b, alu_cin,
      input  rsp_valid, rsp_id, rsp_r, rsp_wr, rsp_err, nzcv
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only when a grant is taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = req;
      if (req == 2'b11)
         gnt = last ? 2'b01 : 2'b10;
   end

   // Resets to 1 so requester 0 wins the first contest.
   always_ff @(posedge clk) begin
      if (reset)
         last <= 1'b1;
      else if (advance)
         last <= gnt[1];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between a datapath and an address requester, two cycles per op.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   state_t      state, state_nxt;
   logic [1:0]  gnt;
   logic        acc0, acc1, accept;
   logic [4:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        id_q, s_q;
   logic        illegal;

   logic        rsp_valid_q, rsp_id_q, rsp_wr_q, rsp_err_q;
   logic [31:0] rsp_r_q;
   logic [3:0]  nzcv_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({bus.req1_valid, bus.req0_valid}),
      .advance (accept),
      .gnt     (gnt)
   );

   assign acc0    = (state == ST_IDLE) && !reset && gnt[0];
   assign acc1    = (state == ST_IDLE) && !reset && gnt[1];
   assign accept  = acc0 || acc1;
   assign illegal = is_illegal_op(op_q);

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.alu_op     = '0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.alu_cin    = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req0_ready = acc0;
            bus.req1_ready = acc1;
            if (accept)
               state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            state_nxt   = ST_IDLE;
            bus.alu_op  = op_q;
            bus.alu_a   = a_q;
            bus.alu_b   = b_q;
            // Carry-in comes from the live flags so a response's C feeds the very next op.
            bus.alu_cin = !id_q && nzcv_q[1];
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= acc0 ? bus.req0_op : bus.req1_op;
         a_q  <= acc0 ? bus.req0_a  : bus.req1_a;
         b_q  <= acc0 ? bus.req0_b  : bus.req1_b;
         s_q  <= acc0 ? bus.req0_s  : 1'b0;
         id_q <= acc1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_r_q     <= '0;
         rsp_wr_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         nzcv_q      <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         if (state == ST_BUSY) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= illegal;
            rsp_r_q     <= illegal ? 32'd0 : bus.alu_r;
            rsp_wr_q    <= !illegal && !is_test_op(op_q);
            if (!id_q && !illegal && (s_q || is_test_op(op_q)))
               nzcv_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_r     = rsp_r_q;
   assign bus.rsp_wr    = rsp_wr_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.nzcv      = nzcv_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock, rising edge) and reset (input, 1, synchronous, active-high).
REQ-002 SHALL have req0_valid (input, 1): datapath requester has an operation.
REQ-003 SHALL have req0_ready (output, 1): req0 accepted on this edge when both are high.
REQ-004 SHALL have req0_op (input, 5), req0_a (input, 32), req0_b (input, 32) and req0_s (input, 1, set-flags).
REQ-005 SHALL have req1_valid (input, 1), req1_ready (output, 1), req1_op (input, 5), req1_a (input, 32) and req1_b (input, 32) for the address-calculation requester.
REQ-006 SHALL have alu_op (output, 5), alu_a (output, 32), alu_b (output, 32) and alu_cin (output, 1) driving the shared combinational ALU.
REQ-007 SHALL have alu_r (input, 32) and alu_c, alu_z, alu_v, alu_n (input, 1 each) returned by the ALU in the same cycle.
REQ-008 SHALL have rsp_valid (output, 1, one-cycle pulse), rsp_id (output, 1, 0=req0, 1=req1), rsp_r (output, 32), rsp_wr (output, 1, result to be written) and rsp_err (output, 1).
REQ-009 SHALL have nzcv (output, 4, status flags [3]=N [2]=Z [1]=C [0]=V).

Function
REQ-010 SHALL implement FSM IDLE->BUSY on accept, and BUSY->IDLE unconditionally after one cycle.
REQ-011 SHALL keep both readies low in BUSY; in IDLE, only the granted requester's ready SHALL be high.
REQ-012 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; last-granted SHALL reset to 1, so req0 wins first.
REQ-013 SHALL register op/a/b/id/s on accept (edge T) and drive alu_* from those registers throughout BUSY (cycle T+1).
REQ-014 SHALL capture the ALU outputs at edge T+2 and hold rsp_valid high for exactly cycle T+2; throughput is one operation per 2 cycles.
REQ-015 SHALL drive alu_cin = nzcv[1] for req0 operations and 0 for req1 operations.
REQ-016 SHALL update nzcv at edge T+2 only when id=0 and either s=1 or op is TST/TEQ/CMP/CMN (01000-01011); req1 SHALL never modify nzcv.
REQ-017 SHALL drive rsp_wr=0 for TST/TEQ/CMP/CMN and rsp_wr=1 for all other legal ops.
REQ-018 SHALL treat opcodes 10111, 11000 and 11011-11111 as illegal: accepted, rsp_err=1, rsp_r=0, rsp_wr=0, nzcv unchanged.
REQ-019 SHALL ensure an op accepted in the IDLE cycle after a flag-setting response sees the updated C on alu_cin.
REQ-020 SHALL drive alu_op/alu_a/alu_b to 0 in IDLE.
REQ-021 SHALL hold rsp_r, rsp_id, rsp_wr and rsp_err at their last values when rsp_valid=0.

Reset
REQ-022 SHALL on reset force FSM=IDLE, nzcv=0000, rsp_valid=0, rsp_r=0, rsp_id=0, rsp_wr=0, rsp_err=0 and last-granted=1.
REQ-023 SHALL, when reset is asserted during BUSY, discard the in-flight op: no rsp_valid pulse and no flag update.
REQ-024 SHALL hold both readies low while reset is high.

Structure
REQ-025 SHALL place the opcode constants (AND..MVN, OP1..OP9), an is_test_op classification and the FSM state encoding in shared package alu_pkg.
REQ-026 SHALL implement arbitration in one sub-module, rr_arb2: two requests in, one-hot grant out, internal last-granted register.

Verification
REQ-027 SHALL test req0 ADD, s=1, A=7F000000, B=0F001000 -> rsp_r=8E001000, rsp_wr=1, nzcv=1001.
REQ-028 SHALL test req0 CMP, A=50000000, B=B0000000 -> rsp_r=A0000000, rsp_wr=0, nzcv=1001.
REQ-029 SHALL test nzcv C=1, then req0 ADC, s=1, A=50000000, B=B0000000 -> alu_cin=1, rsp_r=00000001, nzcv=0010.
REQ-030 SHALL test both requesters held valid for 6 cycles -> grants 0,1,0 on alternating accept edges, and req1 OP5 A=0000000A -> rsp_r=00000006 with nzcv unchanged.
REQ-031 SHALL test reset asserted in BUSY -> no rsp_valid, nzcv=0000, req0 granted first after release.
REQ-032 SHALL test req0 op=11100 -> rsp_valid with rsp_err=1, rsp_r=0 and nzcv unchanged.
